// File: rtl/ccu_cmd_arbiter_if.sv
// Requester, CCU command and status signals shared by the command arbiter.
// slave is the arbiter's view; master is the view of the surrounding requesters and CCU.
interface ccu_cmd_arbiter_if #(
  parameter int DW = 8
);
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          ccu_busy;
  logic [DW-1:0] cmd;
  logic          cmd_valid;
  logic [1:0]    grant;
  logic          pkt_done;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, ccu_busy,
    output req0_ready, req1_ready, cmd, cmd_valid, grant, pkt_done
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, ccu_busy,
    input  req0_ready, req1_ready, cmd, cmd_valid, grant, pkt_done
  );
endinterface

// File: rtl/ccu_cmd_arbiter.sv
// Round-robin arbiter sharing the CCU command byte port between two requesters.
// Each grant covers one PKT_LEN-byte packet and is followed by a GAP wait for the CCU.
module ccu_cmd_arbiter #(
  parameter int DW      = 8,
  parameter int PKT_LEN = 5,
  parameter int GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ccu_cmd_arbiter_if.slave      bus
);

  localparam int CW = $clog2(PKT_LEN + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_WAIT
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_cmd, w_cmd_nxt;
  logic            r_cmd_valid, w_cmd_valid_nxt;
  logic [1:0]      r_grant, w_grant_nxt;
  logic            r_pkt_done, w_pkt_done_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]      r_last_grant, w_last_grant_nxt;
  logic [GW-1:0]   r_gap, w_gap_nxt;

  logic            w_rdy0, w_rdy1, w_hs;
  logic [DW-1:0]   w_data;
  logic [1:0]      w_winner;

  // Readies come only from registered state so they never depend on valid.
  assign w_rdy0 = (r_state == S_XFER) && r_grant[0];
  assign w_rdy1 = (r_state == S_XFER) && r_grant[1];
  assign w_hs   = (w_rdy0 && bus.req0_valid) || (w_rdy1 && bus.req1_valid);
  assign w_data = r_grant[0] ? bus.req0_data : bus.req1_data;

  // On a tie the requester that did not own the previous packet wins.
  assign w_winner = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant
                                                       : {bus.req1_valid, bus.req0_valid};

  always_comb begin
    w_state_nxt      = r_state;
    w_cmd_nxt        = r_cmd;
    w_cmd_valid_nxt  = 1'b0;
    w_grant_nxt      = r_grant;
    w_pkt_done_nxt   = 1'b0;
    w_cnt_nxt        = r_cnt;
    w_last_grant_nxt = r_last_grant;
    w_gap_nxt        = r_gap;

    case (r_state)
      S_IDLE: begin
        if (!bus.ccu_busy && (bus.req0_valid || bus.req1_valid)) begin
          w_state_nxt = S_XFER;
          w_grant_nxt = w_winner;
          w_cnt_nxt   = '0;
        end
      end

      S_XFER: begin
        if (w_hs) begin
          w_cmd_nxt       = w_data;
          w_cmd_valid_nxt = 1'b1;
          w_cnt_nxt       = r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_pkt_done_nxt   = 1'b1;
            w_last_grant_nxt = r_grant;
            w_grant_nxt      = '0;
            w_gap_nxt        = '0;
            w_state_nxt      = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if ((r_gap >= GAP_MAX) && !bus.ccu_busy) begin
          w_state_nxt = S_IDLE;
        end else if (r_gap < GAP_MAX) begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cmd        <= '0;
      r_cmd_valid  <= 1'b0;
      r_grant      <= '0;
      r_pkt_done   <= 1'b0;
      r_cnt        <= '0;
      r_last_grant <= 2'b10;
      r_gap        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cmd        <= w_cmd_nxt;
      r_cmd_valid  <= w_cmd_valid_nxt;
      r_grant      <= w_grant_nxt;
      r_pkt_done   <= w_pkt_done_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gap        <= w_gap_nxt;
    end
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.cmd        = r_cmd;
  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.grant      = r_grant;
  assign bus.pkt_done   = r_pkt_done;

endmodule

// File: tb/tb_ccu_cmd_arbiter.sv
// Directed bench for ccu_cmd_arbiter: per-cycle vector table plus hand-written
// sequences for mid-packet reset and a single-byte-packet instance.
module tb_ccu_cmd_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  ccu_cmd_arbiter_if #(.DW(8)) ia ();
  ccu_cmd_arbiter_if #(.DW(8)) ib ();

  ccu_cmd_arbiter #(.DW(8), .PKT_LEN(5), .GAP(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  ccu_cmd_arbiter #(.DW(8), .PKT_LEN(1), .GAP(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       busy;
    logic       er0;
    logic       er1;
    logic [7:0] ecmd;
    logic       ecv;
    logic [1:0] eg;
    logic       epd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic rs, input logic v0, input int d0, input logic v1, input int d1,
                     input logic b, input logic r0, input logic r1, input int c, input logic cv,
                     input logic [1:0] g, input logic pd);
    vec_t t;
    t.rst = rs;   t.v0 = v0;   t.d0 = 8'(d0); t.v1 = v1;  t.d1 = 8'(d1); t.busy = b;
    t.er0 = r0;   t.er1 = r1;  t.ecmd = 8'(c); t.ecv = cv; t.eg = g;     t.epd = pd;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ia.req0_valid = 1'b0; ia.req0_data = '0;
    ia.req1_valid = 1'b0; ia.req1_data = '0;
    ia.ccu_busy   = 1'b0;
    #1;
    chk("rst cmd",       32'(ia.cmd),        0);
    chk("rst cmd_valid", 32'(ia.cmd_valid),  0);
    chk("rst grant",     32'(ia.grant),      0);
    chk("rst pkt_done",  32'(ia.pkt_done),   0);
    chk("rst ready0",    32'(ia.req0_ready), 0);
    chk("rst ready1",    32'(ia.req1_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dbytes [5];
    int  idx, got, pds, last_c, nb;
    logic hs, r0_seen;

    n_chk = 0; n_err = 0;
    rst_n = 1'b0;
    ia.req0_valid = 1'b0; ia.req0_data = '0; ia.req1_valid = 1'b0; ia.req1_data = '0; ia.ccu_busy = 1'b0;
    ib.req0_valid = 1'b0; ib.req0_data = '0; ib.req1_valid = 1'b0; ib.req1_data = '0; ib.ccu_busy = 1'b0;

    //  rst v0 d0  v1 d1  busy | r0 r1 cmd cv grant pd
    // single packet from req0
    add(1, 1, 0,  0, 0,  0,  0, 0, 0,  0, 2'b00, 0);
    add(0, 1, 0,  0, 0,  0,  1, 0, 0,  0, 2'b01, 0);
    add(0, 1, 0,  0, 0,  0,  1, 0, 0,  1, 2'b01, 0);
    add(0, 1, 50, 0, 0,  0,  1, 0, 0,  1, 2'b01, 0);
    add(0, 1, 30, 0, 0,  0,  1, 0, 50, 1, 2'b01, 0);
    add(0, 1, 10, 0, 0,  0,  1, 0, 30, 1, 2'b01, 0);
    add(0, 0, 0,  0, 0,  0,  0, 0, 10, 1, 2'b00, 1);
    add(0, 0, 0,  0, 0,  0,  0, 0, 10, 0, 2'b00, 0);
    add(0, 0, 0,  0, 0,  0,  0, 0, 10, 0, 2'b00, 0);
    // contention, req1 bubbles, then alternation back to req0
    add(1, 1, 0,  1, 12, 0,  0, 0, 0,  0, 2'b00, 0);
    add(0, 1, 0,  1, 12, 0,  1, 0, 0,  0, 2'b01, 0);
    add(0, 1, 0,  1, 12, 0,  1, 0, 0,  1, 2'b01, 0);
    add(0, 1, 50, 1, 12, 0,  1, 0, 0,  1, 2'b01, 0);
    add(0, 1, 30, 1, 12, 0,  1, 0, 50, 1, 2'b01, 0);
    add(0, 1, 10, 1, 12, 0,  1, 0, 30, 1, 2'b01, 0);
    add(0, 1, 1,  1, 12, 0,  0, 0, 10, 1, 2'b00, 1);
    add(0, 1, 1,  1, 12, 0,  0, 0, 10, 0, 2'b00, 0);
    add(0, 1, 1,  1, 12, 0,  0, 0, 10, 0, 2'b00, 0);
    add(0, 1, 1,  1, 12, 0,  0, 1, 10, 0, 2'b10, 0);
    add(0, 1, 1,  1, 14, 0,  0, 1, 12, 1, 2'b10, 0);
    add(0, 1, 1,  0, 14, 0,  0, 1, 14, 1, 2'b10, 0);
    add(0, 1, 1,  0, 14, 0,  0, 1, 14, 0, 2'b10, 0);
    add(0, 1, 1,  0, 14, 0,  0, 1, 14, 0, 2'b10, 0);
    add(0, 1, 1,  1, 16, 0,  0, 1, 14, 0, 2'b10, 0);
    add(0, 1, 1,  1, 18, 0,  0, 1, 16, 1, 2'b10, 0);
    add(0, 1, 1,  1, 20, 0,  0, 1, 18, 1, 2'b10, 0);
    add(0, 1, 1,  1, 99, 0,  0, 0, 20, 1, 2'b00, 1);
    add(0, 1, 1,  1, 99, 0,  0, 0, 20, 0, 2'b00, 0);
    add(0, 1, 1,  1, 99, 0,  0, 0, 20, 0, 2'b00, 0);
    add(0, 1, 1,  1, 99, 0,  1, 0, 20, 0, 2'b01, 0);
    add(0, 1, 2,  1, 99, 0,  1, 0, 1,  1, 2'b01, 0);
    // ccu_busy through WAIT, then busy while IDLE
    add(1, 1, 0,  0, 0,  0,  0, 0, 0,  0, 2'b00, 0);
    add(0, 1, 0,  0, 0,  0,  1, 0, 0,  0, 2'b01, 0);
    add(0, 1, 0,  0, 0,  0,  1, 0, 0,  1, 2'b01, 0);
    add(0, 1, 50, 0, 0,  0,  1, 0, 0,  1, 2'b01, 0);
    add(0, 1, 30, 0, 0,  0,  1, 0, 50, 1, 2'b01, 0);
    add(0, 1, 10, 0, 0,  0,  1, 0, 30, 1, 2'b01, 0);
    add(0, 1, 1,  0, 0,  1,  0, 0, 10, 1, 2'b00, 1);
    for (int i = 0; i < 9; i++)
      add(0, 1, 1, 0, 0, 1,  0, 0, 10, 0, 2'b00, 0);
    add(0, 1, 1,  0, 0,  0,  0, 0, 10, 0, 2'b00, 0);
    add(0, 1, 1,  0, 0,  1,  0, 0, 10, 0, 2'b00, 0);
    add(0, 1, 1,  0, 0,  1,  0, 0, 10, 0, 2'b00, 0);
    add(0, 1, 1,  0, 0,  0,  0, 0, 10, 0, 2'b00, 0);
    add(0, 1, 1,  0, 0,  0,  1, 0, 10, 0, 2'b01, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      ia.req0_valid = vecs[i].v0; ia.req0_data = vecs[i].d0;
      ia.req1_valid = vecs[i].v1; ia.req1_data = vecs[i].d1;
      ia.ccu_busy   = vecs[i].busy;
      #1;
      chk($sformatf("row%0d ready0", i),    32'(ia.req0_ready), 32'(vecs[i].er0));
      chk($sformatf("row%0d ready1", i),    32'(ia.req1_ready), 32'(vecs[i].er1));
      chk($sformatf("row%0d cmd", i),       32'(ia.cmd),        32'(vecs[i].ecmd));
      chk($sformatf("row%0d cmd_valid", i), 32'(ia.cmd_valid),  32'(vecs[i].ecv));
      chk($sformatf("row%0d grant", i),     32'(ia.grant),      32'(vecs[i].eg));
      chk($sformatf("row%0d pkt_done", i),  32'(ia.pkt_done),   32'(vecs[i].epd));
    end

    // Asynchronous reset after the third byte, then a clean req1 packet.
    do_reset();
    @(negedge clk); ia.req0_valid = 1'b1; ia.req0_data = 8'd0;
    @(negedge clk); ia.req0_data = 8'd0;
    @(negedge clk); ia.req0_data = 8'd0;
    @(negedge clk); ia.req0_data = 8'd50;
    @(posedge clk); #2;
    chk("D pre-reset cmd",       32'(ia.cmd),       50);
    chk("D pre-reset cmd_valid", 32'(ia.cmd_valid), 1);
    rst_n = 1'b0;
    ia.req0_valid = 1'b0;
    #1;
    chk("D async cmd",       32'(ia.cmd),        0);
    chk("D async cmd_valid", 32'(ia.cmd_valid),  0);
    chk("D async grant",     32'(ia.grant),      0);
    chk("D async ready0",    32'(ia.req0_ready), 0);
    @(negedge clk);
    chk("D held cmd_valid", 32'(ia.cmd_valid), 0);
    rst_n = 1'b1;
    dbytes = '{8'd22, 8'd24, 8'd0, 8'd0, 8'd10};
    idx = 0; got = 0; pds = 0; hs = 1'b0; r0_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (hs) idx++;
      if (ia.cmd_valid) begin
        if (got < 5) chk($sformatf("D byte%0d", got), 32'(ia.cmd), 32'(dbytes[got]));
        got++;
      end
      if (ia.pkt_done) begin
        pds++;
        chk("D pkt_done on last byte", 32'(got), 5);
      end
      if (ia.req0_ready) r0_seen = 1'b1;
      ia.req1_valid = (idx < 5);
      ia.req1_data  = (idx < 5) ? dbytes[idx] : 8'd0;
      #1;
      hs = ia.req1_ready && ia.req1_valid;
    end
    ia.req1_valid = 1'b0;
    chk("D bytes out",   32'(got),     5);
    chk("D pkt_done n",  32'(pds),     1);
    chk("D accepted",    32'(idx),     5);
    chk("D ready0 seen", 32'(r0_seen), 0);

    // Single-byte packets alternating between requesters.
    do_reset();
    ib.req0_valid = 1'b1; ib.req0_data = 8'd76;
    ib.req1_valid = 1'b1; ib.req1_data = 8'd24;
    last_c = -1; nb = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      chk($sformatf("E%0d pd_eq_cv", c), 32'(ib.pkt_done), 32'(ib.cmd_valid));
      if (ib.cmd_valid) begin
        chk($sformatf("E byte%0d", nb), 32'(ib.cmd), (nb % 2 == 0) ? 76 : 24);
        if (last_c >= 0) chk($sformatf("E spacing%0d", nb), 32'(c - last_c), 4);
        last_c = c;
        nb++;
      end
    end
    chk("E packets", 32'(nb >= 5), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ccu_cmd_arbiter.md
Name: ccu_cmd_arbiter

Overview:
- Shares the CCU command byte input between two host requesters (req0, req1) of the graphics pipeline.
- Each requester delivers fixed-length draw packets: Xs, Ys, Xe, Ye, color.
- Grants one requester per packet using round-robin and holds the grant for the whole packet.
- Forwards the bytes to the CCU cmd input with a registered valid, then waits for the CCU to finish before the next arbitration.

Parameters:
- DW, 8, command byte width (matches the CCU cmd port).
- PKT_LEN, 5, bytes per packet; minimum 1.
- GAP, 2, minimum cycles spent in WAIT after the last byte; minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 byte valid.
- req0_data  in  DW  requester 0 byte.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid  in  1  requester 1 byte valid.
- req1_data  in  DW  requester 1 byte.
- req1_ready  out  1  requester 1 byte accepted this cycle.
- ccu_busy  in  1  CCU is executing a packet; blocks arbitration.
- cmd  out  DW  byte to the CCU cmd input.
- cmd_valid  out  1  cmd holds a new byte this cycle.
- grant  out  2  one-hot owner of the current packet; 00 when idle.
- pkt_done  out  1  one-cycle pulse coincident with the last byte of a packet on cmd.

Behaviour:
- Reset: state=IDLE, cmd=0, cmd_valid=0, grant=00, pkt_done=0, cnt=0, last_grant=req1 (so req0 wins the first tie), gap counter=0. Reset takes effect immediately whenever rst_n is low.
- Handshake: reqN_ready = (state==XFER && grant[N]). This is combinational from registered state only and never depends on reqN_valid. A byte transfers on a cycle with valid && ready.
- State IDLE:
  - Enter XFER when ccu_busy==0 and (req0_valid || req1_valid).
  - Winner: the only valid requester. If both are valid, the requester that is not last_grant wins.
  - On that edge: grant<=winner, cnt<=0.
  - While ccu_busy==1, stay in IDLE; valids are ignored.
- State XFER:
  - On a transfer: cmd<=data, cmd_valid<=1, cnt<=cnt+1. The byte appears on cmd exactly 1 cycle after the handshake.
  - Without a transfer (bubble): cmd_valid<=0 and cmd holds its value.
  - On the transfer with cnt==PKT_LEN-1:
    - pkt_done is registered high in the same cycle the last byte appears.
    - last_grant<=grant, grant<=00.
    - State moves to WAIT with the gap counter set to 0.
  - The non-granted requester's ready stays 0 for the whole packet, even if the owner stalls indefinitely. No timeout.
- State WAIT:
  - cmd_valid=0 after the last byte's cycle, and both readies are 0.
  - Gap counter increments each cycle.
  - Exit to IDLE when gap>=GAP-1 and ccu_busy==0. The earliest possible re-arbitration is GAP+1 cycles after the last handshake.
  - A ccu_busy rise or fall during WAIT only affects the exit condition.
- Widths: cnt is $clog2(PKT_LEN+1) bits and never wraps within a packet. The gap counter saturates at GAP-1.
- Reset mid-packet: the partial packet is discarded and no further cmd_valid is issued. After release, arbitration restarts with req0 priority.
- Data is never altered; cmd bit-exactly equals the accepted byte.

Test Plan:
- Single packet: req0 streams 0,0,50,30,10 back-to-back, ccu_busy=0 -> req0_ready high for 5 cycles starting 1 cycle after valid. cmd shows 0,0,50,30,10 with cmd_valid for 5 consecutive cycles, each delayed 1 cycle from its handshake. pkt_done high with byte 10. grant=01 during XFER, then 00.
- Contention: req0 and req1 valid simultaneously from reset -> req0 packet (0,0,50,30,10) first, then req1 packet (12,14,16,18,20). With both kept valid, the third packet goes to req0 (alternation). req1_ready stays 0 throughout req0's packet.
- Bubbles: req1 drops valid for 3 cycles after its 2nd byte (12,14,-,-,-,16,18,20) -> cmd_valid low for 3 cycles. cmd holds 14 during them. Remaining bytes arrive in order and pkt_done fires once.
- CCU busy: ccu_busy=1 from the last byte of packet 1 for 10 cycles, req0 valid -> no ready and no grant until the cycle after ccu_busy falls. With ccu_busy=0, the gap between the last handshake and the next grant is exactly GAP+1=3 cycles.
- Reset mid-packet: assert rst_n=0 asynchronously after the 3rd byte (50) -> all outputs 0 immediately. After release, req1 alone valid with 22,24,0,0,10 -> full 5-byte packet and one pkt_done.
- PKT_LEN=1 instance: alternating single-byte requests 76,24 -> each is a complete packet with pkt_done on every cmd_valid, and a GAP respected between them.
